// File: rtl/stage_mem_pkg.sv
// Shared pipeline definitions for the memory stage.
// Holds the FSM state encoding, the memory-op encoding and the op decoder
// used by stage_mem.
package stage_mem_pkg;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    // Memory-op encoding
    typedef logic [1:0] op_t;
    localparam op_t OP_NOP   = 2'd0;
    localparam op_t OP_LOAD  = 2'd1;
    localparam op_t OP_STORE = 2'd2;

    // A store takes priority: a register-write flag on a store is ignored.
    function automatic op_t decode_op(input logic wreg_en, input logic wmem_en);
        if (wmem_en) begin
            return OP_STORE;
        end else if (wreg_en) begin
            return OP_LOAD;
        end
        return OP_NOP;
    endfunction

endpackage

// File: rtl/stage_mem.sv
// Memory pipeline stage.
// Accepts a load/store from ID/EX, issues one registered memory request and
// stalls upstream until the memory acknowledges or the wait times out.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            accept a new op from ID/EX
//   WRegEn_in         op writes a register (load)
//   WMemEn_in         op writes memory (store)
//   r1_data_in        address source (low addr_width bits used)
//   r2_data_in        store data
//   wReg1_in          destination register
//   mem_req/mem_we    registered memory request / write strobe
//   mem_addr/wdata    registered memory address / write data
//   mem_ack/rdata     memory acknowledge / read data
//   stall_out         high while waiting on memory
//   WRegEn_out        one-cycle writeback pulse per completed load
//   wReg1_out         writeback register
//   wData_out         writeback data
//   err_out           sticky timeout flag
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned reg_addr   = 3,
    parameter int unsigned addr_width = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  WRegEn_in,
    input  logic                  WMemEn_in,
    input  logic [data_width-1:0] r1_data_in,
    input  logic [data_width-1:0] r2_data_in,
    input  logic [reg_addr-1:0]   wReg1_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  stall_out,
    output logic                  WRegEn_out,
    output logic [reg_addr-1:0]   wReg1_out,
    output logic [data_width-1:0] wData_out,
    output logic                  err_out
);

    localparam logic [7:0] cnt_last = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic [reg_addr-1:0]   dest_q, dest_d;
    logic                  is_load_q, is_load_d;
    logic                  wen_q, wen_d;
    logic [reg_addr-1:0]   wreg_q, wreg_d;
    logic [data_width-1:0] wb_q, wb_d;
    logic                  err_q, err_d;
    op_t                   op;

    // Upper address bits are intentionally dropped.
    logic unused_r1;
    assign unused_r1 = ^r1_data_in;

    assign op = decode_op(WRegEn_in, WMemEn_in);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        dest_d    = dest_q;
        is_load_d = is_load_q;
        wen_d     = 1'b0;
        wreg_d    = wreg_q;
        wb_d      = wb_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && op != OP_NOP) begin
                    req_d     = 1'b1;
                    we_d      = (op == OP_STORE);
                    addr_d    = r1_data_in[addr_width-1:0];
                    wdata_d   = r2_data_in;
                    dest_d    = wReg1_in;
                    is_load_d = (op == OP_LOAD);
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (is_load_q) begin
                        wen_d  = 1'b1;
                        wb_d   = mem_rdata;
                        wreg_d = dest_q;
                    end
                end else if (cnt_q == cnt_last) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            dest_q    <= '0;
            is_load_q <= 1'b0;
            wen_q     <= 1'b0;
            wreg_q    <= '0;
            wb_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            dest_q    <= dest_d;
            is_load_q <= is_load_d;
            wen_q     <= wen_d;
            wreg_q    <= wreg_d;
            wb_q      <= wb_d;
            err_q     <= err_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign stall_out  = (state_q == ST_WAIT);
    assign WRegEn_out = wen_q;
    assign wReg1_out  = wreg_q;
    assign wData_out  = wb_q;
    assign err_out    = err_q;

endmodule

// File: tb/tb_stage_mem.sv
// Randomized self-checking bench for stage_mem against a transaction-level model.
module tb_stage_mem;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, WRegEn_in, WMemEn_in;
    logic [31:0] r1_data_in, r2_data_in;
    logic [2:0]  wReg1_in;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        stall_out, WRegEn_out, err_out;
    logic [2:0]  wReg1_out;
    logic [31:0] wData_out;

    int tests = 0;
    int fails = 0;

    // Model of architecturally visible writeback / error state
    logic [31:0] exp_wb;
    logic [2:0]  exp_wreg;
    logic        exp_err;

    always #5 clk = ~clk;

    stage_mem #(.data_width(32), .reg_addr(3), .addr_width(8), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .WRegEn_in  (WRegEn_in),
        .WMemEn_in  (WMemEn_in),
        .r1_data_in (r1_data_in),
        .r2_data_in (r2_data_in),
        .wReg1_in   (wReg1_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall_out  (stall_out),
        .WRegEn_out (WRegEn_out),
        .wReg1_out  (wReg1_out),
        .wData_out  (wData_out),
        .err_out    (err_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"}, mem_req, 0);
        chk({tag, ".we"}, mem_we, 0);
        chk({tag, ".addr"}, mem_addr, 0);
        chk({tag, ".wdata"}, mem_wdata, 0);
        chk({tag, ".stall"}, stall_out, 0);
        chk({tag, ".wen"}, WRegEn_out, 0);
        chk({tag, ".wreg"}, wReg1_out, 0);
        chk({tag, ".wb"}, wData_out, 0);
        chk({tag, ".err"}, err_out, 0);
    endtask

    // Present one op for one edge; ack arrives on WAIT cycle d (1 = earliest).
    task automatic do_op(input logic en, input logic wreg, input logic wmem,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [2:0] dst, input int d, input logic [31:0] rdata);
        logic active, store, load, ok;
        int   done;
        enable     = en;
        WRegEn_in  = wreg;
        WMemEn_in  = wmem;
        r1_data_in = r1;
        r2_data_in = r2;
        wReg1_in   = dst;
        mem_ack    = 1'($urandom);   // ack while idle must be ignored
        mem_rdata  = $urandom;
        active = en && (wreg || wmem);
        store  = wmem;
        load   = wreg && !wmem;
        tick();
        chk("accept.stall", stall_out, active);
        chk("accept.req", mem_req, active);
        chk("accept.wen", WRegEn_out, 0);
        chk("accept.wb", wData_out, exp_wb);
        chk("accept.err", err_out, exp_err);
        if (!active) begin
            return;
        end
        chk("accept.we", mem_we, store);
        chk("accept.addr", mem_addr, r1[7:0]);
        chk("accept.wdata", mem_wdata, r2);
        done = (d < TO) ? d : TO;
        ok   = (d <= TO);
        for (int k = 1; k <= done; k++) begin
            enable     = 1'($urandom);
            WRegEn_in  = 1'($urandom);
            WMemEn_in  = 1'($urandom);
            r1_data_in = $urandom;
            r2_data_in = $urandom;
            wReg1_in   = 3'($urandom);
            mem_ack    = (k == d);
            mem_rdata  = (k == d) ? rdata : $urandom;
            tick();
            if (k < done) begin
                chk("wait.stall", stall_out, 1);
                chk("wait.req", mem_req, 1);
                chk("wait.we", mem_we, store);
                chk("wait.addr", mem_addr, r1[7:0]);
                chk("wait.wdata", mem_wdata, r2);
                chk("wait.wen", WRegEn_out, 0);
            end else begin
                if (ok && load) begin
                    exp_wb   = rdata;
                    exp_wreg = dst;
                end
                if (!ok) begin
                    exp_err = 1'b1;
                end
                chk("done.stall", stall_out, 0);
                chk("done.req", mem_req, 0);
                chk("done.wen", WRegEn_out, ok && load);
                chk("done.wreg", wReg1_out, exp_wreg);
                chk("done.wb", wData_out, exp_wb);
                chk("done.err", err_out, exp_err);
            end
        end
        mem_ack = 1'b0;
        enable  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 0; WRegEn_in = 0; WMemEn_in = 0;
        r1_data_in = 0; r2_data_in = 0; wReg1_in = 0;
        mem_ack = 0; mem_rdata = 0;
        exp_wb = 0; exp_wreg = 0; exp_err = 0;
        #2;
        chk_all_zero("reset");
        tick();
        reset = 1'b0;

        // Load with minimum latency
        do_op(1, 1, 0, 32'h0000_0012, 32'h0, 3'd3, 1, 32'hDEAD_BEEF);
        // Store with WRegEn_in also set, ack after 5 cycles
        do_op(1, 1, 1, 32'h0000_0040, 32'h0000_CAFE, 3'd5, 5, 32'h1234_5678);
        // Ack on the last WAIT cycle before timeout
        do_op(1, 1, 0, 32'hFFFF_FF33, 32'h0, 3'd6, TO, 32'h0BAD_F00D);
        // No ack: timeout, then a normal load
        do_op(1, 1, 0, 32'h0000_0077, 32'h0, 3'd2, 100, 32'h5555_5555);
        do_op(1, 1, 0, 32'h0000_0078, 32'h0, 3'd1, 1, 32'hA5A5_A5A5);

        for (int i = 0; i < 80; i++) begin
            do_op(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, 3'($urandom), $urandom_range(1, 20), $urandom);
        end

        // Reset in the middle of a wait
        do_op(1, 1, 0, 32'h0000_0099, 32'h0, 3'd7, 100, 32'h0);
        enable = 1; WRegEn_in = 1; WMemEn_in = 0; r1_data_in = 32'h21; wReg1_in = 3'd4;
        tick();
        chk("rst.pre_req", mem_req, 1);
        enable = 0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_wb = 0; exp_wreg = 0; exp_err = 0;
        chk_all_zero("rst.async");
        tick();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk_all_zero("rst.spurious_ack");
        mem_ack = 1'b0;
        do_op(1, 1, 0, 32'h0000_0012, 32'h0, 3'd3, 2, 32'hC0DE_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter data_width, default 32, datapath width.
REQ-002 Parameter reg_addr, default 3, register-address width.
REQ-003 Parameter addr_width, default 8, data-memory address width.
REQ-004 Parameter TIMEOUT, default 16, max WAIT cycles before abort (range 2..255).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 enable  input  1  accept new op from ID/EX outputs when high.
REQ-008 WRegEn_in  input  1  op writes register (load).
REQ-009 WMemEn_in  input  1  op writes memory (store).
REQ-010 r1_data_in  input  data_width  address source, low addr_width bits used.
REQ-011 r2_data_in  input  data_width  store data.
REQ-012 wReg1_in  input  reg_addr  destination register.
REQ-013 mem_req / mem_we  output  1 each  memory request / write strobe, registered.
REQ-014 mem_addr  output  addr_width; mem_wdata  output  data_width; both registered.
REQ-015 mem_ack  input  1; mem_rdata  input  data_width, valid when mem_ack high.
REQ-016 stall_out  output  1  upstream must hold ID/EX outputs while high.
REQ-017 WRegEn_out  output  1; wReg1_out  output  reg_addr; wData_out  output  data_width  writeback.
REQ-018 err_out  output  1  sticky timeout flag.

Function
REQ-019 Decode: WMemEn_in=1 -> STORE (WRegEn_in ignored); WRegEn_in=1, WMemEn_in=0 -> LOAD; otherwise NOP.
REQ-020 States IDLE, WAIT; stall_out = (state==WAIT), decoded from the state register only.
REQ-021 IDLE, enable=1, LOAD/STORE: on the edge, mem_req<=1, mem_we<=STORE, mem_addr/mem_wdata/dest latched, counter<=0, go WAIT.
REQ-022 IDLE, enable=1, NOP, or enable=0: no request; stays IDLE.
REQ-023 WAIT: inputs ignored; mem_req, mem_we, mem_addr, mem_wdata held constant until ack or abort.
REQ-024 WAIT, mem_ack=1: mem_req<=0, go IDLE; LOAD -> WRegEn_out<=1, wData_out<=mem_rdata, wReg1_out<=latched dest; STORE -> no writeback.
REQ-025 WRegEn_out is a one-cycle pulse per completed load; 0 on all other cycles; wData_out/wReg1_out hold their last value.
REQ-026 Minimum latency: op sampled at edge N, ack sampled at edge N+1, WRegEn_out high after edge N+1; stall_out high for exactly one cycle.
REQ-027 Counter increments every WAIT cycle without ack; if mem_ack=0 at counter==TIMEOUT-1, abort: mem_req<=0, IDLE, err_out<=1, no writeback.
REQ-028 mem_ack and timeout on the same edge: ack wins (normal completion, err_out unchanged).
REQ-029 mem_ack in IDLE: ignored, no output change.
REQ-030 err_out stays 1 until reset; a new op is accepted normally after abort.
REQ-031 Back-to-back: the first IDLE cycle after completion accepts the next op if enable=1.

Reset
REQ-032 Reset forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-033 Reset forces WRegEn_out=0, wReg1_out=0, wData_out=0, err_out=0, stall_out=0.
REQ-034 Reset during WAIT drops mem_req immediately (asynchronous); the transaction is abandoned with no writeback.

Structure
REQ-035 Shared pipeline package holds the state encoding (IDLE=0, WAIT=1) and the NOP/LOAD/STORE op encoding.
REQ-036 No sub-module; decode, FSM, timeout counter and output registers are inline.

Verification
REQ-037 Load addr 0x12, ack one cycle after req with rdata 0xDEADBEEF, dest 3 -> single WRegEn_out pulse, wReg1_out=3, wData_out=0xDEADBEEF, stall_out high 1 cycle.
REQ-038 Store addr 0x40 data 0x0000CAFE with WRegEn_in=1, ack after 5 cycles -> mem_we=1, fields stable 5 cycles, no WRegEn_out pulse.
REQ-039 Load, no ack for 16 cycles -> mem_req falls, err_out=1, no writeback; next load with immediate ack completes normally.
REQ-040 Ack on exactly the 16th WAIT cycle -> completion, err_out stays 0.
REQ-041 Reset asserted mid-WAIT -> mem_req=0 and all outputs 0 before the next edge; spurious ack after reset produces no output change.
